// File: rtl/juego_pkg.sv
// ---------------------------------------------------------------------------
// juego_pkg
// Shared definitions for the memory-game board: FSM state codes consumed by
// tablero_memoria, board dimensions and the LFSR feedback mask.
// ---------------------------------------------------------------------------
package juego_pkg;

    localparam int N_CARTAS = 16;               // board slots, power of two
    localparam int VAL_W    = 3;                // card value width
    localparam int PARES    = N_CARTAS / 2;     // number of pairs
    localparam int IDX_W    = $clog2(N_CARTAS); // slot index width

    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [3:0] {
        INICIO         = 4'd0,
        MUESTRO        = 4'd1,
        OCULTA         = 4'd2,
        REVUELVE       = 4'd3,
        INICIO_JUEGO   = 4'd4,
        TURNO          = 4'd5,
        UNA_CARTA      = 4'd6,
        DOS_CARTAS     = 4'd7,
        MOSTRAR_RANDOM = 4'd8,
        NO_MAS_PAREJAS = 4'd9,
        CONCLUSION     = 4'd10
    } estado_t;

endpackage

// File: rtl/lfsr16.sv
// ---------------------------------------------------------------------------
// lfsr16
// Free-running 16-bit Galois LFSR (right shift, feedback mask LFSR_TAPS).
// Advances every clock; loads SEED on reset. SEED must be nonzero.
// Ports:
//   clk  in   system clock
//   rst  in   asynchronous active-low reset
//   q    out  current LFSR state
// ---------------------------------------------------------------------------
module lfsr16
    import juego_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) q <= SEED;
        else      q <= {1'b0, q[15:1]} ^ (q[0] ? LFSR_TAPS : 16'h0000);
    end

endmodule

// File: rtl/tablero_memoria.sv
// ---------------------------------------------------------------------------
// tablero_memoria
// Card-board responder for the memory-game FSM. Owns the board (values,
// visibility, matched flags), runs the show/hide/shuffle sweeps, accepts
// player and random picks, evaluates pairs, and returns the handshakes.
// Ports:
//   clk, rst               clock, asynchronous active-low reset
//   state[3:0]             FSM state code (estado_t)
//   sel_valid, sel_idx     one-cycle player pick strobe and slot
//   cartas_mostradas       show sweep done (level, while in MUESTRO)
//   cartas_ocultas         hide sweep done (level, while in OCULTA)
//   cartas_revueltas       shuffle done (level, while in REVUELVE)
//   se_eligio_carta        pick accepted (1-cycle pulse)
//   cartas_seleccionadas   face-up cards in current turn (0..2)
//   pareja_encontrada      match pulse from pair evaluation
//   pares_encontrados      matched pairs (0..PARES)
//   card_val               slot values, slot i at [i*VAL_W +: VAL_W]
//   card_visible           slot face-up or matched
// ---------------------------------------------------------------------------
module tablero_memoria
    import juego_pkg::*;
#(
    parameter logic [15:0] SEMILLA = 16'hACE1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [3:0]                state,
    input  logic                      sel_valid,
    input  logic [IDX_W-1:0]          sel_idx,
    output logic                      cartas_mostradas,
    output logic                      cartas_ocultas,
    output logic                      cartas_revueltas,
    output logic                      se_eligio_carta,
    output logic [1:0]                cartas_seleccionadas,
    output logic                      pareja_encontrada,
    output logic [3:0]                pares_encontrados,
    output logic [N_CARTAS*VAL_W-1:0] card_val,
    output logic [N_CARTAS-1:0]       card_visible
);

    logic [VAL_W-1:0]    val [N_CARTAS];
    logic [N_CARTAS-1:0] vis, mat;
    logic [IDX_W:0]      idx;          // sweep/scan position, saturates at N_CARTAS
    logic [3:0]          prev_state;
    logic [IDX_W-1:0]    pick0, pick1, rnd_start;

    logic [IDX_W-1:0]    lfsr_lo;
    logic [15-IDX_W:0]   lfsr_unused;

    lfsr16 #(.SEED(SEMILLA)) u_lfsr (
        .clk (clk),
        .rst (rst),
        .q   ({lfsr_unused, lfsr_lo})
    );

    // A state change restarts the phase on the same edge: the first cycle in
    // a state already acts on position 0.
    logic           entry;
    logic [IDX_W:0] eff;
    logic [IDX_W-1:0] scan_slot;
    logic           turn_open, sel_ok, scan_ok;
    logic           acc_en;
    logic [IDX_W-1:0] acc_slot;

    localparam logic [IDX_W:0] SWEEP_END = (IDX_W+1)'(N_CARTAS);

    assign entry     = (state != prev_state);
    assign eff       = entry ? '0 : idx;
    assign scan_slot = entry ? lfsr_lo : rnd_start + idx[IDX_W-1:0];
    assign turn_open = (cartas_seleccionadas < 2'd2);
    assign sel_ok    = !mat[sel_idx]   && !vis[sel_idx]   && turn_open;
    assign scan_ok   = !mat[scan_slot] && !vis[scan_slot] && turn_open;

    // Player picks and the random scan share one acceptance path.
    always_comb begin
        acc_en   = 1'b0;
        acc_slot = sel_idx;
        case (state)
            TURNO, UNA_CARTA: acc_en = sel_valid && sel_ok;
            MOSTRAR_RANDOM: begin
                acc_slot = scan_slot;
                acc_en   = (eff < SWEEP_END) && scan_ok;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N_CARTAS; i++) val[i] <= VAL_W'(i >> 1);
            vis                  <= '0;
            mat                  <= '0;
            idx                  <= '0;
            prev_state           <= INICIO;
            pick0                <= '0;
            pick1                <= '0;
            rnd_start            <= '0;
            cartas_mostradas     <= 1'b0;
            cartas_ocultas       <= 1'b0;
            cartas_revueltas     <= 1'b0;
            se_eligio_carta      <= 1'b0;
            cartas_seleccionadas <= '0;
            pareja_encontrada    <= 1'b0;
            pares_encontrados    <= '0;
        end else begin
            prev_state        <= state;
            idx               <= eff;
            se_eligio_carta   <= 1'b0;
            pareja_encontrada <= 1'b0;
            if (entry) begin
                cartas_mostradas <= 1'b0;
                cartas_ocultas   <= 1'b0;
                cartas_revueltas <= 1'b0;
            end

            if (acc_en) begin
                vis[acc_slot] <= 1'b1;
                if (cartas_seleccionadas == 2'd0) pick0 <= acc_slot;
                else                              pick1 <= acc_slot;
                cartas_seleccionadas <= cartas_seleccionadas + 2'd1;
                se_eligio_carta      <= 1'b1;
            end

            case (state)
                INICIO: begin
                    mat                  <= '0;
                    vis                  <= '0;
                    pares_encontrados    <= '0;
                    cartas_seleccionadas <= '0;
                end
                MUESTRO: begin
                    if (eff < SWEEP_END) begin
                        vis[eff[IDX_W-1:0]] <= 1'b1;
                        idx <= eff + 1'b1;
                    end else cartas_mostradas <= 1'b1;
                end
                OCULTA: begin
                    if (eff < SWEEP_END) begin
                        vis[eff[IDX_W-1:0]] <= 1'b0;
                        idx <= eff + 1'b1;
                    end else cartas_ocultas <= 1'b1;
                end
                REVUELVE: begin
                    // Non-blocking swap reads both old values: always a permutation.
                    if (eff < SWEEP_END) begin
                        val[eff[IDX_W-1:0]] <= val[lfsr_lo];
                        val[lfsr_lo]        <= val[eff[IDX_W-1:0]];
                        idx <= eff + 1'b1;
                    end else cartas_revueltas <= 1'b1;
                end
                MOSTRAR_RANDOM: begin
                    if (entry) rnd_start <= lfsr_lo;
                    // A hit parks the scan at the end so only one pick is made.
                    if (eff < SWEEP_END) idx <= acc_en ? SWEEP_END : eff + 1'b1;
                end
                DOS_CARTAS: begin
                    if (eff == '0) begin
                        idx <= 1;
                        if (cartas_seleccionadas == 2'd2) begin
                            if (val[pick0] == val[pick1]) begin
                                mat[pick0]        <= 1'b1;
                                mat[pick1]        <= 1'b1;
                                pareja_encontrada <= 1'b1;
                                if (pares_encontrados < 4'(PARES))
                                    pares_encontrados <= pares_encontrados + 4'd1;
                            end else begin
                                vis[pick0] <= 1'b0;
                                vis[pick1] <= 1'b0;
                            end
                            cartas_seleccionadas <= '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    genvar g;
    generate
        for (g = 0; g < N_CARTAS; g++) begin : g_val
            assign card_val[g*VAL_W +: VAL_W] = val[g];
        end
    endgenerate

    assign card_visible = vis | mat;

endmodule

// File: tb/tb_tablero_memoria.sv
// ---------------------------------------------------------------------------
// tb_tablero_memoria
// Directed bench for tablero_memoria with a cycle-level board model.
// ---------------------------------------------------------------------------
module tb_tablero_memoria;
    import juego_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  state = 4'd0;
    logic        sel_valid = 1'b0;
    logic [3:0]  sel_idx = 4'd0;
    logic        cartas_mostradas, cartas_ocultas, cartas_revueltas;
    logic        se_eligio_carta, pareja_encontrada;
    logic [1:0]  cartas_seleccionadas;
    logic [3:0]  pares_encontrados;
    logic [47:0] card_val;
    logic [15:0] card_visible;

    tablero_memoria dut (
        .clk(clk), .rst(rst), .state(state), .sel_valid(sel_valid), .sel_idx(sel_idx),
        .cartas_mostradas(cartas_mostradas), .cartas_ocultas(cartas_ocultas),
        .cartas_revueltas(cartas_revueltas), .se_eligio_carta(se_eligio_carta),
        .cartas_seleccionadas(cartas_seleccionadas), .pareja_encontrada(pareja_encontrada),
        .pares_encontrados(pares_encontrados), .card_val(card_val), .card_visible(card_visible)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // ---------------- board model ----------------
    int          mval [16];
    bit          mvis [16];
    bit          mmat [16];
    int          picks [$];
    int          mpares, mprev, mk, mstart;
    logic [15:0] mlfsr;
    bit          mmos, moc, mrev, mse, mpe;

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            mval[i] = i / 2; mvis[i] = 0; mmat[i] = 0;
        end
        picks.delete();
        mpares = 0; mprev = 0; mk = 0; mstart = 0;
        mlfsr = 16'hACE1;
        mmos = 0; moc = 0; mrev = 0; mse = 0; mpe = 0;
    endtask

    function automatic bit eligible(input int s);
        return !mmat[s] && !mvis[s] && (picks.size() < 2);
    endfunction

    task automatic take(input int s);
        mvis[s] = 1;
        picks.push_back(s);
        mse = 1;
    endtask

    task automatic model_step();
        int k, st, j, t, s, a, b;
        st = int'(state);
        if (st != mprev) begin
            k = 0; mmos = 0; moc = 0; mrev = 0;
        end else k = mk;
        mprev = st;
        mse = 0; mpe = 0;
        case (st)
            0: begin
                for (int i = 0; i < 16; i++) begin mvis[i] = 0; mmat[i] = 0; end
                picks.delete();
                mpares = 0;
            end
            1: if (k < 16) begin mvis[k] = 1; k++; end else mmos = 1;
            2: if (k < 16) begin mvis[k] = 0; k++; end else moc = 1;
            3: if (k < 16) begin
                   j = int'(mlfsr[3:0]);
                   t = mval[k]; mval[k] = mval[j]; mval[j] = t;
                   k++;
               end else mrev = 1;
            5, 6: if (sel_valid && eligible(int'(sel_idx))) take(int'(sel_idx));
            7: if (k == 0) begin
                   k = 1;
                   if (picks.size() == 2) begin
                       a = picks[0]; b = picks[1];
                       if (mval[a] == mval[b]) begin
                           mmat[a] = 1; mmat[b] = 1; mpe = 1;
                           if (mpares < 8) mpares++;
                       end else begin
                           mvis[a] = 0; mvis[b] = 0;
                       end
                       picks.delete();
                   end
               end
            8: begin
                if (k == 0) mstart = int'(mlfsr[3:0]);
                if (k < 16) begin
                    s = (mstart + k) % 16;
                    if (eligible(s)) begin take(s); k = 16; end
                    else k++;
                end
            end
            default: ;
        endcase
        mk = k;
        mlfsr = mlfsr[0] ? ((mlfsr >> 1) ^ 16'hB400) : (mlfsr >> 1);
    endtask

    task automatic compare_all();
        logic [63:0] ev, vv;
        ev = '0; vv = '0;
        for (int i = 0; i < 16; i++) begin
            ev[i*3 +: 3] = 3'(mval[i]);
            vv[i]        = mvis[i] | mmat[i];
        end
        check("mostradas", cartas_mostradas, mmos);
        check("ocultas",   cartas_ocultas,   moc);
        check("revueltas", cartas_revueltas, mrev);
        check("eligio",    se_eligio_carta,  mse);
        check("pareja",    pareja_encontrada, mpe);
        check("sel_cnt",   cartas_seleccionadas, picks.size());
        check("pares",     pares_encontrados, mpares);
        check("card_val",  card_val, ev);
        check("visible",   card_visible, vv);
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst) model_reset(); else model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic pick(input int s);
        sel_valid = 1'b1; sel_idx = 4'(s);
        tick();
        sel_valid = 1'b0;
    endtask

    task automatic run_phase(input int st, output int rise);
        logic d;
        state = 4'(st); rise = 0;
        for (int t = 1; t <= 20; t++) begin
            tick();
            d = (st == 1) ? cartas_mostradas : (st == 2) ? cartas_ocultas : cartas_revueltas;
            if (rise == 0 && d) rise = t;
            if (st == 1 && t == 16) check("show_full", card_visible, 16'hFFFF);
        end
    endtask

    task automatic match_pair(input int x, input int y);
        state = 4'd5; tick();
        pick(x); pick(y);
        state = 4'd7; tick(); tick();
    endtask

    initial begin
        int rise, a, b, c, d, cnt, got, u1, u2, other;
        model_reset();

        // 1. reset
        rst = 1'b0; state = 4'd0;
        repeat (2) tick();
        check("rst_slot5",  card_val[15 +: 3], 3'd2);
        check("rst_slot14", card_val[42 +: 3], 3'd7);
        check("rst_vis",    card_visible, 16'h0);
        rst = 1'b1;
        repeat (2) tick();

        // 2. show / hide sweeps
        run_phase(1, rise);
        check("show_rise", rise, 17);
        run_phase(2, rise);
        check("hide_rise", rise, 17);
        check("hide_vis",  card_visible, 16'h0);

        // 3. shuffle
        run_phase(3, rise);
        check("shuf_rise", rise, 17);
        for (int v = 0; v < 8; v++) begin
            cnt = 0;
            for (int i = 0; i < 16; i++) if (card_val[i*3 +: 3] == 3'(v)) cnt++;
            check("hist", cnt, 2);
        end

        // 4. matching pair
        state = 4'd5; tick();
        a = 0; b = 1;
        for (int i = 1; i < 16; i++) if (mval[i] == mval[0]) b = i;
        pick(a);
        check("pick1_pulse", se_eligio_carta, 1);
        check("pick1_cnt",   cartas_seleccionadas, 1);
        pick(b);
        check("pick2_pulse", se_eligio_carta, 1);
        check("pick2_cnt",   cartas_seleccionadas, 2);
        state = 4'd7; tick();
        check("match_pulse", pareja_encontrada, 1);
        check("match_count", pares_encontrados, 1);
        tick();
        check("match_once",  pareja_encontrada, 0);

        // 5. unequal pair, then re-pick of a matched slot
        state = 4'd5; tick();
        c = -1; d = -1;
        for (int i = 0; i < 16; i++) if (c < 0 && !mmat[i]) c = i;
        for (int i = 0; i < 16; i++) if (d < 0 && !mmat[i] && mval[i] != mval[c]) d = i;
        pick(c); pick(d);
        state = 4'd7; tick();
        check("miss_vis",   {card_visible[c], card_visible[d]}, 2'b00);
        check("miss_count", pares_encontrados, 1);
        state = 4'd5; tick();
        pick(a);
        check("matched_repick", se_eligio_carta, 0);

        // 6. all but one pair matched, then random pick
        while (mpares < 7) begin
            a = -1; b = -1;
            for (int i = 0; i < 16; i++) if (a < 0 && !mmat[i]) a = i;
            for (int i = 0; i < 16; i++) if (b < 0 && i != a && !mmat[i] && mval[i] == mval[a]) b = i;
            match_pair(a, b);
        end
        u1 = -1; u2 = -1;
        for (int i = 0; i < 16; i++) if (!mmat[i]) begin if (u1 < 0) u1 = i; else u2 = i; end
        state = 4'd8; got = 0;
        for (int t = 0; t < 20 && got == 0; t++) begin
            tick();
            if (se_eligio_carta) got = 1;
        end
        check("rnd_pulse", got, 1);
        check("rnd_slot",  int'(card_visible[u1]) + int'(card_visible[u2]), 1);
        other = mvis[u1] ? u2 : u1;
        state = 4'd5; tick();
        pick(other);
        state = 4'd7; tick();
        check("all_pairs", pares_encontrados, 8);

        // INICIO clears the game
        state = 4'd0; tick();
        check("inicio_pares", pares_encontrados, 0);
        check("inicio_vis",   card_visible, 16'h0);

        // reset in the middle of a sweep
        state = 4'd5; tick();
        pick(3);
        state = 4'd1;
        repeat (5) tick();
        #2 rst = 1'b0;
        model_reset();
        #1;
        check("midrst_flags", {cartas_mostradas, cartas_ocultas, cartas_revueltas,
                               se_eligio_carta, pareja_encontrada}, 5'b0);
        check("midrst_cnt",   cartas_seleccionadas, 0);
        check("midrst_vis",   card_visible, 16'h0);
        check("midrst_slot5", card_val[15 +: 3], 3'd2);
        compare_all();
        repeat (2) tick();
        rst = 1'b1; state = 4'd0;
        repeat (3) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
